vga_timing_gen: RTL and testbench

Raster timing generator for the VGA output path, sitting directly downstream of the 100 MHz → 25 MHz pixel-rate divider. It runs entirely on `sys_clk` and advances one pixel per `pix_en` strobe. It produces `hsync`, `vsync`, the data-enable signal, the pixel coordinates and frame/line markers for the pixel-data stage. An optional built-in colour-bar pattern can be compiled in for bring-up.

---
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the VGA output path. The block runs on sys_clk
// and advances one pixel position each time the pix_en strobe is high. It
// produces the sync pulses, the data-enable flag, the pixel coordinates and
// the line/frame start markers used by the pixel-data stage.
//
// Optional feature (compile-time macro VGA_TEST_PATTERN_EN):
//   defined     - rgb carries eight vertical colour bars during active video
//   not defined - rgb is tied to 12'h000 and no pattern logic exists
//
// Ports:
//   sys_clk      in   1      system clock (only clock)
//   sys_rst_n    in   1      asynchronous active-low reset
//   pix_en       in   1      pixel-advance strobe, one sys_clk wide
//   hsync        out  1      horizontal sync (polarity from SYNC_POL)
//   vsync        out  1      vertical sync   (polarity from SYNC_POL)
//   de           out  1      active-video flag
//   pixel_x      out  CNT_W  horizontal position
//   pixel_y      out  CNT_W  vertical position
//   line_start   out  1      one-cycle pulse after x moves to 0
//   frame_start  out  1      one-cycle pulse after (x,y) moves to (0,0)
//   rgb          out  12     4:4:4 pixel colour
//
// All outputs are registered and change only on the edge where pix_en is
// sampled high, except the start pulses which also clear when pix_en is low.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [11:0]      rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] x_r, y_r;
  logic [CNT_W-1:0] next_x_s, next_y_s;
  logic             hsync_r, vsync_r, de_r, line_start_r, frame_start_r;
  logic             hsync_next_s, vsync_next_s, de_next_s;

  // Next raster position and the decodes of that position, so registered
  // outputs line up with the coordinates they describe.
  always_comb begin
    next_x_s = x_r;
    next_y_s = y_r;
    if (x_r == H_LAST) begin
      next_x_s = ZERO_C;
      if (y_r == V_LAST) begin
        next_y_s = ZERO_C;
      end else begin
        next_y_s = y_r + ONE_C;
      end
    end else begin
      next_x_s = x_r + ONE_C;
    end
    de_next_s    = (next_x_s < H_ACT_C) && (next_y_s < V_ACT_C);
    hsync_next_s = ((next_x_s >= HS_BEG) && (next_x_s < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_next_s = ((next_y_s >= VS_BEG) && (next_y_s < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
  end

  // Raster counters, sync/enable flags and start pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_r           <= H_LAST;
      y_r           <= V_LAST;
      hsync_r       <= ~SYNC_ACT;
      vsync_r       <= ~SYNC_ACT;
      de_r          <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (pix_en) begin
      x_r           <= next_x_s;
      y_r           <= next_y_s;
      hsync_r       <= hsync_next_s;
      vsync_r       <= vsync_next_s;
      de_r          <= de_next_s;
      line_start_r  <= (next_x_s == ZERO_C);
      frame_start_r <= (next_x_s == ZERO_C) && (next_y_s == ZERO_C);
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  logic [11:0] rgb_r;

  // Colour of the vertical bar containing column x (white first, black last).
  function automatic logic [11:0] bar_colour(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] idx;
    idx = x / BAR_W;
    case (idx)
      CNT_W'(0): bar_colour = 12'hFFF;
      CNT_W'(1): bar_colour = 12'hFF0;
      CNT_W'(2): bar_colour = 12'h0FF;
      CNT_W'(3): bar_colour = 12'h0F0;
      CNT_W'(4): bar_colour = 12'hF0F;
      CNT_W'(5): bar_colour = 12'hF00;
      CNT_W'(6): bar_colour = 12'h00F;
      default:   bar_colour = 12'h000;
    endcase
  endfunction

  // Pattern colour, registered with de and blanked outside active video.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_r <= 12'h000;
    end else if (pix_en) begin
      rgb_r <= de_next_s ? bar_colour(next_x_s) : 12'h000;
    end else begin
      rgb_r <= rgb_r;
    end
  end

  assign rgb = rgb_r;
`else
  assign rgb = 12'h000;
`endif

  assign pixel_x     = x_r;
  assign pixel_y     = y_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two instances from one pix_en / reset stream: one with the default
// 640x480 timing and one with a tiny raster (25 x 12, active-high sync) so
// that whole frames, vertical wraps and vsync are reached quickly. Expected
// outputs come from the number of pixel advances since reset, turned into
// (x,y) by division/modulo and decoded straight from the timing parameters.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Small raster parameters
  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 3;
  localparam int S_W  = 5;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic        d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
  logic [9:0]  d0_x, d0_y;
  logic [11:0] d0_rgb;

  logic           d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
  logic [S_W-1:0] d1_x, d1_y;
  logic [11:0]    d1_rgb;

  int    n_checks = 0;
  int    n_errors = 0;
  longint n_adv = 0;   // pixel advances since the last reset
  bit    prev_adv = 1'b0;

  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  always #5 sys_clk = ~sys_clk;

  vga_timing_gen u_dut_def (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_en(pix_en),
    .hsync(d0_hs), .vsync(d0_vs), .de(d0_de),
    .pixel_x(d0_x), .pixel_y(d0_y),
    .line_start(d0_ls), .frame_start(d0_fs), .rgb(d0_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1), .CNT_W(S_W)
  ) u_dut_small (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_en(pix_en),
    .hsync(d1_hs), .vsync(d1_vs), .de(d1_de),
    .pixel_x(d1_x), .pixel_y(d1_y),
    .line_start(d1_ls), .frame_start(d1_fs), .rgb(d1_rgb)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, adv=%0d)", tag, got, exp, $time, n_adv);
    end
  endtask

  // Compare one instance against the raster derived from n_adv.
  task automatic check_dut(input string id,
                           input int ha, input int hfp, input int hs, input int htot,
                           input int va, input int vfp, input int vs, input int vtot,
                           input bit pol,
                           input logic [31:0] ox, input logic [31:0] oy,
                           input logic ohs, input logic ovs, input logic ode,
                           input logic ols, input logic ofs, input logic [11:0] orgb);
    longint ex, ey;
    bit ede, ehs, evs, els, efs;
    logic [11:0] ergb;
    if (n_adv == 0) begin
      ex = htot - 1;
      ey = vtot - 1;
    end else begin
      ex = (n_adv - 1) % htot;
      ey = ((n_adv - 1) / htot) % vtot;
    end
    ede = (ex < ha) && (ey < va);
    ehs = (ex >= ha + hfp && ex < ha + hfp + hs) ? pol : ~pol;
    evs = (ey >= va + vfp && ey < va + vfp + vs) ? pol : ~pol;
    els = prev_adv && (ex == 0);
    efs = prev_adv && (ex == 0) && (ey == 0);
`ifdef VGA_TEST_PATTERN_EN
    ergb = ede ? bars[ex / (ha / 8)] : 12'h000;
`else
    ergb = 12'h000;
`endif
    check_value({id, ".pixel_x"},     ox, 32'(ex));
    check_value({id, ".pixel_y"},     oy, 32'(ey));
    check_value({id, ".de"},          32'(ode), 32'(ede));
    check_value({id, ".hsync"},       32'(ohs), 32'(ehs));
    check_value({id, ".vsync"},       32'(ovs), 32'(evs));
    check_value({id, ".line_start"},  32'(ols), 32'(els));
    check_value({id, ".frame_start"}, 32'(ofs), 32'(efs));
    check_value({id, ".rgb"},         32'(orgb), 32'(ergb));
  endtask

  task automatic check_all();
    check_dut("def", 640, 16, 96, 800, 480, 10, 2, 525, 1'b0,
              32'(d0_x), 32'(d0_y), d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d0_rgb);
    check_dut("small", S_HA, S_HFP, S_HS, S_HA + S_HFP + S_HS + S_HBP,
              S_VA, S_VFP, S_VS, S_VA + S_VFP + S_VS + S_VBP, 1'b1,
              32'(d1_x), 32'(d1_y), d1_hs, d1_vs, d1_de, d1_ls, d1_fs, d1_rgb);
  endtask

  // One sys_clk cycle with the given strobe; outputs checked on the falling edge.
  task automatic cycle(input bit pe);
    pix_en = pe;
    @(posedge sys_clk);
    if (sys_rst_n) begin
      prev_adv = pe;
      if (pe) n_adv++;
    end else begin
      prev_adv = 1'b0;
    end
    @(negedge sys_clk);
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic mid_reset();
    #2;
    sys_rst_n = 1'b0;
    n_adv     = 0;
    prev_adv  = 1'b0;
    #1;
    check_all();
    @(negedge sys_clk);
    check_all();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, then the first advance lands on (0,0)
    pix_en = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_all();
    sys_rst_n = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);

    // One and a bit lines at one pixel every fourth cycle
    for (int i = 0; i < 4 * 900; i++) cycle((i % 4) == 3);

    // Reset mid-line, then continuous strobe across several lines
    mid_reset();
    for (int i = 0; i < 2500; i++) cycle(1'b1);

    // Random strobe density with occasional mid-frame resets
    for (int i = 0; i < 24000; i++) begin
      if ($urandom_range(0, 3999) == 0) mid_reset();
      case ($urandom_range(0, 2))
        0:       cycle($urandom_range(0, 3) == 0);
        1:       cycle($urandom_range(0, 1) == 0);
        default: cycle(1'b1);
      endcase
    end

    // Reset while the default raster sits at x = 300 on line 0
    mid_reset();
    for (int i = 0; i < 301; i++) cycle(1'b1);
    check_value("def.x_at_300", 32'(d0_x), 32'd300);
    mid_reset();
    cycle(1'b1);
    check_value("def.origin_after_reset", {22'd0, d0_x} | {22'd0, d0_y}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
